// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared AXI-Stream widths, word layout and RX write-FSM states
//                for the 10G Ethernet receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    // One stored beat: last flag, byte enables, payload
    typedef struct packed {
        logic                   tlast;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_word_t;

    // Write-side frame FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port with read enable (read data holds when not enabled).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_ram #(
    parameter int WIDTH  = 73,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output holds its value while i_re is low
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rx_frame_filter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_filter_fifo
//  Description : Store-and-forward RX FIFO. Buffers whole frames and forwards
//                only frames that ended with tuser=0 and fitted in the buffer.
//                Optional statistics counters: define RX_FRAME_FILTER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_filter_fifo
    import eth_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int KEEP_W = AXIS_KEEP_W,
    parameter int ADDR_W = 9
) (
    input  logic              clk156,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              overflow,
    output logic              bad_frame
`ifdef RX_FRAME_FILTER_STATS_EN
    ,
    output logic [31:0]       good_cnt,
    output logic [31:0]       bad_cnt,
    output logic [31:0]       ovf_cnt
`endif
);

    localparam int              c_WORD_W = 1 + KEEP_W + DATA_W;
    localparam logic [ADDR_W:0] c_DEPTH  = {1'b1, {ADDR_W{1'b0}}};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic              r_tready;
    wr_state_t         r_state;
    wr_state_t         w_state_nxt;
    logic [ADDR_W:0]   r_wr_spec;
    logic [ADDR_W:0]   w_wr_spec_nxt;
    logic [ADDR_W:0]   r_wr_commit;
    logic [ADDR_W:0]   w_wr_commit_nxt;
    logic              r_overflow;
    logic              w_overflow_nxt;
    logic              r_bad_frame;
    logic              w_bad_frame_nxt;
    logic              w_we;
    logic              w_accept;
    logic              w_full;

    // Read side
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_ram_vld;
    logic              r_m_valid;
    logic [c_WORD_W-1:0] r_m_word;
    logic [c_WORD_W-1:0] w_ram_rdata;
    logic              w_readable;
    logic              w_load;
    logic              w_rd_en;

    assign w_accept = s_axis_tvalid & r_tready;
    // Space is measured against the read pointer: beats already prefetched
    // out of the RAM no longer occupy a slot.
    assign w_full   = ((r_wr_spec - r_rd_ptr) == c_DEPTH);

    // Input ready: low in reset, high from the first cycle after it
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
        end
    end

    // Write FSM state and pointer registers
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_overflow  <= 1'b0;
            r_bad_frame <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_spec   <= w_wr_spec_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_overflow  <= w_overflow_nxt;
            r_bad_frame <= w_bad_frame_nxt;
        end
    end

    // Write FSM next state: speculative write, commit on good tlast, rewind
    // to the last commit point on bad frames or lack of space
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_spec_nxt   = r_wr_spec;
        w_wr_commit_nxt = r_wr_commit;
        w_overflow_nxt  = 1'b0;
        w_bad_frame_nxt = 1'b0;
        w_we            = 1'b0;
        case (r_state)
            IDLE, WRITE: begin
                if (w_accept) begin
                    if (w_full) begin
                        w_wr_spec_nxt = r_wr_commit;
                        if (s_axis_tlast) begin
                            w_overflow_nxt = 1'b1;
                            w_state_nxt    = IDLE;
                        end else begin
                            w_state_nxt    = DROP;
                        end
                    end else begin
                        w_we          = 1'b1;
                        w_wr_spec_nxt = r_wr_spec + 1'b1;
                        w_state_nxt   = WRITE;
                        if (s_axis_tlast) begin
                            w_state_nxt = IDLE;
                            if (s_axis_tuser) begin
                                w_wr_spec_nxt   = r_wr_commit;
                                w_bad_frame_nxt = 1'b1;
                            end else begin
                                w_wr_commit_nxt = r_wr_spec + 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (w_accept && s_axis_tlast) begin
                    w_overflow_nxt = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    rx_frame_ram #(
        .WIDTH  (c_WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk156),
        .i_we    (w_we),
        .i_waddr (r_wr_spec[ADDR_W-1:0]),
        .i_wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read side: RAM output acts as a prefetch stage ahead of the output
    // register, so a read is issued whenever the prefetch slot is free or
    // is being drained this cycle.
    // ------------------------------------------------------------------
    assign w_readable = (r_rd_ptr != r_wr_commit);
    assign w_load     = r_ram_vld & (~r_m_valid | m_axis_tready);
    assign w_rd_en    = w_readable & (~r_ram_vld | w_load);

    // Read pointer and prefetch-valid tracking
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_ram_vld <= w_rd_en | (r_ram_vld & ~w_load);
        end
    end

    // Output register: load from prefetch, hold while stalled
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_word  <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_word  <= w_ram_rdata;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = r_m_valid;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = r_m_word;
    assign overflow      = r_overflow;
    assign bad_frame     = r_bad_frame;

`ifdef RX_FRAME_FILTER_STATS_EN
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
    logic [31:0] r_ovf_cnt;

    // Event counters; a commit is the only thing that moves wr_commit
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_wr_commit_nxt != r_wr_commit) begin
                r_good_cnt <= sat_inc32(r_good_cnt);
            end
            if (w_bad_frame_nxt) begin
                r_bad_cnt <= sat_inc32(r_bad_cnt);
            end
            if (w_overflow_nxt) begin
                r_ovf_cnt <= sat_inc32(r_ovf_cnt);
            end
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
    assign ovf_cnt  = r_ovf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_filter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_filter_fifo
//  Description : Self-checking bench for rx_frame_filter_fifo: frame table,
//                scoreboard queue and hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_filter_fifo;

    logic        clk156 = 1'b0;
    logic        reset  = 1'b1;
    logic [63:0] s_axis_tdata  = '0;
    logic [7:0]  s_axis_tkeep  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast  = 1'b0;
    logic        s_axis_tuser  = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        overflow;
    logic        bad_frame;
`ifdef RX_FRAME_FILTER_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic [31:0] ovf_cnt;
`endif

    always #5 clk156 = ~clk156;

    rx_frame_filter_fifo dut (
        .clk156        (clk156),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .bad_frame     (bad_frame)
`ifdef RX_FRAME_FILTER_STATS_EN
        ,
        .good_cnt      (good_cnt),
        .bad_cnt       (bad_cnt),
        .ovf_cnt       (ovf_cnt)
`endif
    );

    typedef struct {
        int nbeats;
        bit tuser;
    } vec_t;

    vec_t        vecs[8];
    logic [72:0] sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          n_bad = 0;
    int          n_ovf = 0;
    int          rdy_mode = 0;   // 0 low, 1 high, 2 toggle every cycle
    logic [63:0] first_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk156);
        #1;
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk156);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ~m_axis_tready;
            endcase
        end
    end

    // Output monitor: scoreboard pop, stall stability, pulse counting
    initial begin
        logic        p_valid;
        logic        p_ready;
        logic [72:0] p_word;
        logic [72:0] exp_w;
        p_valid = 1'b0;
        p_ready = 1'b0;
        p_word  = '0;
        forever begin
            @(negedge clk156);
            if (reset) begin
                p_valid = 1'b0;
            end else begin
                if (p_valid && !p_ready) begin
                    check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                          {1'b1, p_word});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
                    end else begin
                        exp_w = sb_q.pop_front();
                        check("scoreboard", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_w);
                        n_pop++;
                    end
                end
                if (bad_frame) n_bad++;
                if (overflow)  n_ovf++;
                p_valid = m_axis_tvalid;
                p_ready = m_axis_tready;
                p_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            end
        end
    end

    // Drive one frame; beats of frames expected to pass go to the scoreboard
    task automatic send_frame(input int n, input bit tuser, input bit expect_pass);
        int          g;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        g = 0;
        while (!s_axis_tready && g < 100) begin
            tick();
            g++;
        end
        if (!s_axis_tready) check("s_tready_wait", s_axis_tready, 1);
        for (int i = 0; i < n; i++) begin
            l = (i == n - 1);
            d = {$urandom, $urandom};
            k = l ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
            if (i == 0) first_data = d;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = l;
            s_axis_tuser  = l ? tuser : 1'b0;
            if (expect_pass) sb_q.push_back({l, k, d});
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb_q.size() != 0 || m_axis_tvalid) && g < 5000) begin
            tick();
            g++;
        end
        repeat (2) tick();
        check("drain_queue_empty", sb_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b0;
        int o0;

        vecs[0] = '{8, 1'b1};
        vecs[1] = '{4, 1'b0};
        vecs[2] = '{1, 1'b0};
        vecs[3] = '{1, 1'b1};
        vecs[4] = '{2, 1'b0};
        vecs[5] = '{191, 1'b0};
        vecs[6] = '{3, 1'b1};
        vecs[7] = '{5, 1'b0};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast",  m_axis_tlast, 0);
        check("rst_m_tdata",  {m_axis_tkeep, m_axis_tdata}, 0);
        check("rst_pulses",   {overflow, bad_frame}, 0);
        reset = 1'b0;
        tick();
        check("s_tready_after_rst", s_axis_tready, 1);

        // Good 8-beat frame and its latency
        rdy_mode = 1;
        repeat (2) tick();
        send_frame(8, 1'b0, 1'b1);
        check("t1_valid_at_tlast", m_axis_tvalid, 0);
        tick();
        check("t1_valid_plus1", m_axis_tvalid, 0);
        tick();
        check("t1_valid_plus2", m_axis_tvalid, 1);
        check("t1_first_data", m_axis_tdata, first_data);
        drain();

        // Frame table
        for (int v = 0; v < 8; v++) begin
            p0 = n_pop;
            b0 = n_bad;
            send_frame(vecs[v].nbeats, vecs[v].tuser, !vecs[v].tuser);
            if (vecs[v].tuser) begin
                repeat (4) tick();
                check("vec_no_output", m_axis_tvalid, 0);
            end
            drain();
            check("vec_bad_pulses", n_bad - b0, vecs[v].tuser ? 1 : 0);
            check("vec_beats_out", n_pop - p0, vecs[v].tuser ? 0 : vecs[v].nbeats);
        end

        // Overflow with downstream stalled
        rdy_mode = 0;
        repeat (2) tick();
        p0 = n_pop;
        for (int f = 0; f < 10; f++) send_frame(50, 1'b0, 1'b1);
        o0 = n_ovf;
        send_frame(20, 1'b0, 1'b0);
        check("ovf_pulse_high", overflow, 1);
        tick();
        check("ovf_pulse_low", overflow, 0);
        check("ovf_pulse_count", n_ovf - o0, 1);
        rdy_mode = 1;
        drain();
        check("ovf_drained_beats", n_pop - p0, 500);

        // Back-pressure toggling
        rdy_mode = 2;
        p0 = n_pop;
        send_frame(16, 1'b0, 1'b1);
        drain();
        check("bp_beats_out", n_pop - p0, 16);
        rdy_mode = 1;
        repeat (2) tick();

        // Pointer wrap
        p0 = n_pop;
        for (int f = 0; f < 47; f++) send_frame(64, 1'b0, 1'b1);
        drain();
        check("wrap_beats_out", n_pop - p0, 47 * 64);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b0;
            tick();
        end
        reset = 1'b1;
        tick();
        check("mid_rst_m_tvalid", m_axis_tvalid, 0);
        check("mid_rst_s_tready", s_axis_tready, 0);
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        check("mid_rst_s_tready_back", s_axis_tready, 1);
`ifdef RX_FRAME_FILTER_STATS_EN
        check("stats_cleared", {good_cnt, bad_cnt, ovf_cnt}, 0);
`endif
        p0 = n_pop;
        send_frame(5, 1'b0, 1'b1);
        drain();
        check("mid_rst_next_frame", n_pop - p0, 5);
`ifdef RX_FRAME_FILTER_STATS_EN
        check("stats_good_one", good_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
